// File: rtl/mc_axi_if_pkg.sv
// Shared AXI4 manager/subordinate channel bundles for the memory-controller ports.
package mc_axi_if_pkg;

  localparam int MC_AXI_ID_WIDTH   = 4;
  localparam int MC_AXI_ADDR_WIDTH = 32;
  localparam int MC_AXI_DATA_WIDTH = 32;

  typedef struct packed {
    logic                           awvalid;
    logic [MC_AXI_ID_WIDTH-1:0]     awid;
    logic [MC_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                     awlen;
    logic [3:0]                     awqos;
    logic                           wvalid;
    logic [MC_AXI_DATA_WIDTH-1:0]   wdata;
    logic [MC_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                           wlast;
    logic                           bready;
    logic                           arvalid;
    logic [MC_AXI_ID_WIDTH-1:0]     arid;
    logic [MC_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                     arlen;
    logic [3:0]                     arqos;
    logic                           rready;
  } t_to_mc_axi4;

  typedef struct packed {
    logic                         awready;
    logic                         wready;
    logic                         bvalid;
    logic [MC_AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                   bresp;
    logic                         arready;
    logic                         rvalid;
    logic [MC_AXI_ID_WIDTH-1:0]   rid;
    logic [MC_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                   rresp;
    logic                         rlast;
  } t_from_mc_axi4;

endpackage

// File: rtl/mc_axi_arb_wfifo.sv
// Write-order FIFO: remembers which requester owns each accepted AW until its wlast.
module mc_axi_arb_wfifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 1
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/mc_axi_arbiter.sv
// Two-requester AXI4 arbiter toward one memory controller port.
// Define MC_AXI_ARB_QOS_EN to arbitrate AW/AR by awqos/arqos, round-robin on ties.
//
// state   | meaning
// ST_IDLE | no grant; decision made combinationally from current requests
// ST_HOLD | grant locked until the address handshake completes
module mc_axi_arbiter
  import mc_axi_if_pkg::*;
#(
  parameter int WFIFO_DEPTH = 4,
  parameter int ARB_ID_BIT  = mc_axi_if_pkg::MC_AXI_ID_WIDTH-1
) (
  input  logic                         refclk,
  input  logic                         ip2hdm_reset_n,
  input  t_to_mc_axi4                  req0_to_mc_axi4,
  output t_from_mc_axi4                req0_from_mc_axi4,
  input  t_to_mc_axi4                  req1_to_mc_axi4,
  output t_from_mc_axi4                req1_from_mc_axi4,
  output t_to_mc_axi4                  arb2mc_to_mc_axi4,
  input  t_from_mc_axi4                mc2arb_from_mc_axi4,
  output logic [$clog2(WFIFO_DEPTH):0] arb_wfifo_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  t_to_mc_axi4   req_in [2];
  t_from_mc_axi4 rsp    [2];
  t_to_mc_axi4   aw_src, ar_src, w_src;

  // channel index 0 = AW, 1 = AR
  logic [1:0] ch_vld [2];
  logic [1:0] ch_state, last_gnt, gnt_q, pick, gnt, hs;
  logic       aw_fwd_vld, ar_fwd_vld, w_fwd_vld;
  logic       fifo_full, fifo_empty, fifo_head, fifo_pop;
  logic       w_sel, w_en, b_dst, r_dst;

  assign req_in[0] = req0_to_mc_axi4;
  assign req_in[1] = req1_to_mc_axi4;

  always_comb begin
    ch_vld[0] = {req_in[1].awvalid, req_in[0].awvalid};
    ch_vld[1] = {req_in[1].arvalid, req_in[0].arvalid};
    for (int c = 0; c < 2; c++) begin
      pick[c] = (&ch_vld[c]) ? ~last_gnt[c] : ch_vld[c][1];
      gnt[c]  = (ch_state[c] == ST_HOLD) ? gnt_q[c] : pick[c];
    end
`ifdef MC_AXI_ARB_QOS_EN
    if (&ch_vld[0] && (req_in[0].awqos != req_in[1].awqos))
      pick[0] = (req_in[1].awqos > req_in[0].awqos);
    if (&ch_vld[1] && (req_in[0].arqos != req_in[1].arqos))
      pick[1] = (req_in[1].arqos > req_in[0].arqos);
    for (int c = 0; c < 2; c++)
      gnt[c] = (ch_state[c] == ST_HOLD) ? gnt_q[c] : pick[c];
`endif
  end

  assign aw_src = req_in[gnt[0]];
  assign ar_src = req_in[gnt[1]];

  // A full FIFO hides AW from the controller, so a push can never be lost.
  assign aw_fwd_vld = ip2hdm_reset_n & aw_src.awvalid & ~fifo_full;
  assign ar_fwd_vld = ip2hdm_reset_n & ar_src.arvalid;
  assign hs[0]      = aw_fwd_vld & mc2arb_from_mc_axi4.awready;
  assign hs[1]      = ar_fwd_vld & mc2arb_from_mc_axi4.arready;

  always_ff @(posedge refclk or negedge ip2hdm_reset_n) begin
    if (!ip2hdm_reset_n) begin
      ch_state <= {ST_IDLE, ST_IDLE};
      last_gnt <= 2'b11;
      gnt_q    <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (ch_state[c])
          ST_IDLE: begin
            if (hs[c]) begin
              last_gnt[c] <= pick[c];
            end else if (|ch_vld[c]) begin
              ch_state[c] <= ST_HOLD;
              gnt_q[c]    <= pick[c];
            end
          end
          default: begin
            if (hs[c]) begin
              ch_state[c] <= ST_IDLE;
              last_gnt[c] <= gnt_q[c];
            end
          end
        endcase
      end
    end
  end

  // Empty FIFO: W may only pass alongside the AW that owns it.
  assign w_sel     = fifo_empty ? gnt[0] : fifo_head;
  assign w_en      = ~fifo_empty | hs[0];
  assign w_src     = req_in[w_sel];
  assign w_fwd_vld = ip2hdm_reset_n & w_en & w_src.wvalid;
  assign fifo_pop  = w_fwd_vld & mc2arb_from_mc_axi4.wready & w_src.wlast;

  mc_axi_arb_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .DW    (1)
  ) u_wfifo (
    .clk_sys (refclk),
    .rst_b   (ip2hdm_reset_n),
    .push    (hs[0]),
    .din     (gnt[0]),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .cnt     (arb_wfifo_cnt)
  );

  assign b_dst = mc2arb_from_mc_axi4.bid[ARB_ID_BIT];
  assign r_dst = mc2arb_from_mc_axi4.rid[ARB_ID_BIT];

  always_comb begin
    arb2mc_to_mc_axi4                 = '0;
    arb2mc_to_mc_axi4.awvalid         = aw_fwd_vld;
    arb2mc_to_mc_axi4.awid            = aw_src.awid;
    arb2mc_to_mc_axi4.awid[ARB_ID_BIT] = gnt[0];
    arb2mc_to_mc_axi4.awaddr          = aw_src.awaddr;
    arb2mc_to_mc_axi4.awlen           = aw_src.awlen;
    arb2mc_to_mc_axi4.awqos           = aw_src.awqos;
    arb2mc_to_mc_axi4.wvalid          = w_fwd_vld;
    arb2mc_to_mc_axi4.wdata           = w_src.wdata;
    arb2mc_to_mc_axi4.wstrb           = w_src.wstrb;
    arb2mc_to_mc_axi4.wlast           = w_src.wlast;
    arb2mc_to_mc_axi4.bready          = ip2hdm_reset_n & req_in[b_dst].bready;
    arb2mc_to_mc_axi4.arvalid         = ar_fwd_vld;
    arb2mc_to_mc_axi4.arid            = ar_src.arid;
    arb2mc_to_mc_axi4.arid[ARB_ID_BIT] = gnt[1];
    arb2mc_to_mc_axi4.araddr          = ar_src.araddr;
    arb2mc_to_mc_axi4.arlen           = ar_src.arlen;
    arb2mc_to_mc_axi4.arqos           = ar_src.arqos;
    arb2mc_to_mc_axi4.rready          = ip2hdm_reset_n & req_in[r_dst].rready;
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rsp[r]                 = mc2arb_from_mc_axi4;
      rsp[r].bid[ARB_ID_BIT] = 1'b0;
      rsp[r].rid[ARB_ID_BIT] = 1'b0;
      rsp[r].awready = hs[0] & (gnt[0] == 1'(r));
      rsp[r].arready = hs[1] & (gnt[1] == 1'(r));
      rsp[r].wready  = ip2hdm_reset_n & w_en & (w_sel == 1'(r)) & mc2arb_from_mc_axi4.wready;
      rsp[r].bvalid  = ip2hdm_reset_n & mc2arb_from_mc_axi4.bvalid & (b_dst == 1'(r));
      rsp[r].rvalid  = ip2hdm_reset_n & mc2arb_from_mc_axi4.rvalid & (r_dst == 1'(r));
    end
  end

  assign req0_from_mc_axi4 = rsp[0];
  assign req1_from_mc_axi4 = rsp[1];

endmodule

// File: tb/tb_mc_axi_arbiter.sv
// Directed bench for mc_axi_arbiter: AR arbitration/response-routing table plus
// hand sequences for AW hold, FIFO full, W ordering, bypass, B routing and reset.
module tb_mc_axi_arbiter;
  import mc_axi_if_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  t_to_mc_axi4   r0, r1, mc_to;
  t_from_mc_axi4 r0_rsp, r1_rsp, mc_rsp;
  logic [2:0]    cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mc_axi_arbiter #(.WFIFO_DEPTH(4), .ARB_ID_BIT(3)) dut (
    .refclk              (clk),
    .ip2hdm_reset_n      (rst_n),
    .req0_to_mc_axi4     (r0),
    .req0_from_mc_axi4   (r0_rsp),
    .req1_to_mc_axi4     (r1),
    .req1_from_mc_axi4   (r1_rsp),
    .arb2mc_to_mc_axi4   (mc_to),
    .mc2arb_from_mc_axi4 (mc_rsp),
    .arb_wfifo_cnt       (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    r0 = '0;
    r1 = '0;
    mc_rsp = '0;
    r0.arid = 4'b0101; r0.araddr = 32'h1000; r0.awid = 4'b0001; r0.awaddr = 32'h1100;
    r1.arid = 4'b0110; r1.araddr = 32'h2000; r1.awid = 4'b0001; r1.awaddr = 32'h2200;
    mc_rsp.rid = 4'b0011;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // step to the next drive point (negedge); checks happen #2 after driving
  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic a0, a1, ardy, rv, rid_hi;
    logic e_arv, e_gnt, e_rdy0, e_rdy1, e_rv0, e_rv1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1,1,1, 1,1,  1,0,1,0, 0,1};
    tbl[1]  = '{1,1,1, 1,0,  1,1,0,1, 1,0};
    tbl[2]  = '{1,1,1, 0,0,  1,0,1,0, 0,0};
    tbl[3]  = '{1,1,1, 1,1,  1,1,0,1, 0,1};
    tbl[4]  = '{0,1,1, 0,0,  1,1,0,1, 0,0};
    tbl[5]  = '{1,0,1, 1,0,  1,0,1,0, 1,0};
    tbl[6]  = '{0,0,1, 0,0,  0,0,0,0, 0,0};
    tbl[7]  = '{1,1,0, 0,0,  1,1,0,0, 0,0};
    tbl[8]  = '{1,1,0, 0,0,  1,1,0,0, 0,0};
    tbl[9]  = '{1,1,1, 0,0,  1,1,0,1, 0,0};
    tbl[10] = '{1,1,1, 0,0,  1,0,1,0, 0,0};

    clr_inputs();
    rst_n = 1'b0;
    // outputs forced low in reset even with traffic presented
    r0.arvalid = 1; r1.awvalid = 1; r0.wvalid = 1;
    mc_rsp.arready = 1; mc_rsp.awready = 1; mc_rsp.wready = 1;
    mc_rsp.rvalid = 1; mc_rsp.bvalid = 1;
    #2;
    chk("rst_arvalid", mc_to.arvalid, 0);
    chk("rst_awvalid", mc_to.awvalid, 0);
    chk("rst_wvalid",  mc_to.wvalid, 0);
    chk("rst_r0_arready", r0_rsp.arready, 0);
    chk("rst_r1_awready", r1_rsp.awready, 0);
    chk("rst_r0_rvalid", r0_rsp.rvalid, 0);
    chk("rst_r0_bvalid", r0_rsp.bvalid, 0);
    chk("rst_cnt", cnt, 0);
    do_reset();

    // AR round-robin, hold and R routing
    for (int i = 0; i < 11; i++) begin
      r0.arvalid = tbl[i].a0;
      r1.arvalid = tbl[i].a1;
      mc_rsp.arready = tbl[i].ardy;
      mc_rsp.rvalid = tbl[i].rv;
      mc_rsp.rid = {tbl[i].rid_hi, 3'b011};
      #2;
      chk($sformatf("v%0d_arvalid", i), mc_to.arvalid, tbl[i].e_arv);
      if (tbl[i].e_arv) begin
        chk($sformatf("v%0d_arid", i), mc_to.arid, tbl[i].e_gnt ? 4'b1110 : 4'b0101);
        chk($sformatf("v%0d_araddr", i), mc_to.araddr, tbl[i].e_gnt ? 32'h2000 : 32'h1000);
      end
      chk($sformatf("v%0d_r0_arready", i), r0_rsp.arready, tbl[i].e_rdy0);
      chk($sformatf("v%0d_r1_arready", i), r1_rsp.arready, tbl[i].e_rdy1);
      chk($sformatf("v%0d_r0_rvalid", i), r0_rsp.rvalid, tbl[i].e_rv0);
      chk($sformatf("v%0d_r1_rvalid", i), r1_rsp.rvalid, tbl[i].e_rv1);
      chk($sformatf("v%0d_r1_rid", i), r1_rsp.rid, 4'b0011);
      step();
    end

    // requester 1 AW stalled 5 cycles, requester 0 joins and waits
    do_reset();
    r1.awvalid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) r0.awvalid = 1;
      #2;
      chk($sformatf("awhold%0d_awvalid", i), mc_to.awvalid, 1);
      chk($sformatf("awhold%0d_awid", i), mc_to.awid, 4'b1001);
      chk($sformatf("awhold%0d_awaddr", i), mc_to.awaddr, 32'h2200);
      chk($sformatf("awhold%0d_r0_awready", i), r0_rsp.awready, 0);
      step();
    end
    mc_rsp.awready = 1;
    #2;
    chk("awhold_r1_awready", r1_rsp.awready, 1);
    chk("awhold_r0_awready", r0_rsp.awready, 0);
    chk("awhold_awaddr_hs", mc_to.awaddr, 32'h2200);
    step();
    r1.awvalid = 0;
    #2;
    chk("awhold_r0_next_awaddr", mc_to.awaddr, 32'h1100);
    chk("awhold_r0_next_awready", r0_rsp.awready, 1);
    step();
    r0.awvalid = 0;
    #2;
    chk("awhold_cnt", cnt, 2);

    // fill the write-order FIFO with no W data
    do_reset();
    r0.awvalid = 1; mc_rsp.awready = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("fill%0d_cnt", i), cnt, 3'(i));
      chk($sformatf("fill%0d_awready", i), r0_rsp.awready, 1);
      step();
    end
    #2;
    chk("full_cnt", cnt, 4);
    chk("full_r0_awready", r0_rsp.awready, 0);
    chk("full_awvalid", mc_to.awvalid, 0);
    r0.wvalid = 1; r0.wlast = 1; mc_rsp.wready = 1;
    #1;
    chk("full_w_wready", r0_rsp.wready, 1);
    chk("full_w_wvalid", mc_to.wvalid, 1);
    step();
    r0.wvalid = 0;
    #2;
    chk("pop_cnt", cnt, 3);
    chk("pop_r0_awready", r0_rsp.awready, 1);

    // W ordering: AW0 len 4 then AW1 len 2, requester 1 data shown first
    do_reset();
    mc_rsp.awready = 1; mc_rsp.wready = 1;
    r0.awvalid = 1; r0.awlen = 8'd3;
    step();
    r0.awvalid = 0; r1.awvalid = 1; r1.awlen = 8'd1;
    step();
    r1.awvalid = 0;
    r1.wvalid = 1; r1.wdata = 32'hB0; r1.wlast = 0;
    #2;
    chk("word_cnt", cnt, 2);
    chk("word_r1_early_wvalid", mc_to.wvalid, 0);
    chk("word_r1_early_wready", r1_rsp.wready, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      r0.wvalid = 1; r0.wdata = 32'hA0 + k; r0.wlast = (k == 3);
      #2;
      chk($sformatf("word_r0_b%0d_wdata", k), mc_to.wdata, 32'hA0 + k);
      chk($sformatf("word_r0_b%0d_r0_wready", k), r0_rsp.wready, 1);
      chk($sformatf("word_r0_b%0d_r1_wready", k), r1_rsp.wready, 0);
      step();
    end
    r0.wvalid = 0; r0.wlast = 0;
    for (int k = 0; k < 2; k++) begin
      r1.wvalid = 1; r1.wdata = 32'hB0 + k; r1.wlast = (k == 1);
      #2;
      chk($sformatf("word_r1_b%0d_wdata", k), mc_to.wdata, 32'hB0 + k);
      chk($sformatf("word_r1_b%0d_r1_wready", k), r1_rsp.wready, 1);
      step();
    end
    r1.wvalid = 0; r1.wlast = 0;
    #2;
    chk("word_cnt_end", cnt, 0);

    // empty FIFO: W only passes together with its AW; push+pop keeps count
    r0.wvalid = 1; r0.wlast = 1; r0.wdata = 32'hC0;
    #2;
    chk("bypass_no_aw_wvalid", mc_to.wvalid, 0);
    chk("bypass_no_aw_wready", r0_rsp.wready, 0);
    step();
    r0.awvalid = 1;
    #2;
    chk("bypass_wvalid", mc_to.wvalid, 1);
    chk("bypass_wready", r0_rsp.wready, 1);
    step();
    r0.awvalid = 0; r0.wvalid = 0; r0.wlast = 0;
    #2;
    chk("bypass_cnt", cnt, 0);

    // B routing by bid bit 3
    mc_rsp.bvalid = 1; mc_rsp.bid = 4'b1010;
    r1.bready = 1; r0.bready = 0;
    #2;
    chk("b1_r1_bvalid", r1_rsp.bvalid, 1);
    chk("b1_r0_bvalid", r0_rsp.bvalid, 0);
    chk("b1_r1_bid", r1_rsp.bid, 4'b0010);
    chk("b1_bready", mc_to.bready, 1);
    r1.bready = 0; r0.bready = 1;
    #1;
    chk("b1_bready_from_r1_only", mc_to.bready, 0);
    mc_rsp.bid = 4'b0010;
    #1;
    chk("b0_r0_bvalid", r0_rsp.bvalid, 1);
    chk("b0_r1_bvalid", r1_rsp.bvalid, 0);
    chk("b0_bready", mc_to.bready, 1);
    step();

    // reset asserted mid-burst discards the pending write
    do_reset();
    mc_rsp.awready = 1; mc_rsp.wready = 1;
    r0.awvalid = 1; r0.awlen = 8'd3;
    step();
    r0.awvalid = 0; r0.wvalid = 1; r0.wlast = 0;
    step();
    #2;
    chk("mid_cnt_before", cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_cnt_reset", cnt, 0);
    chk("mid_wvalid_reset", mc_to.wvalid, 0);
    step();
    rst_n = 1'b1;
    #2;
    chk("mid_wvalid_after", mc_to.wvalid, 0);
    chk("mid_r0_wready_after", r0_rsp.wready, 0);
    clr_inputs();

`ifdef MC_AXI_ARB_QOS_EN
    do_reset();
    mc_rsp.arready = 1;
    r0.arvalid = 1; r1.arvalid = 1; r0.arqos = 4'h2; r1.arqos = 4'h8;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("qos_hi%0d_gnt", i), mc_to.arid[3], 1);
      step();
    end
    r0.arqos = 4'h5; r1.arqos = 4'h5;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("qos_eq%0d_gnt", i), mc_to.arid[3], 1'(i % 2));
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
